msg_sched_seq: RTL and testbench
================================

Name: msg_sched_seq

Overview:
- Sequential SHA-256 message scheduler. Accepts one 512-bit block and streams W[0..ROUNDS-1], one word per output handshake, to the compression round engine.
- Keeps a 16-word sliding window, so the full 2048-bit schedule is never held.
- Successor to the combinational schedule stub: adds a parametrised round count, a valid/ready flow on both sides, round index and last-word tags, and back-to-back block overlap.

Parameters:
- WORD_W, 32, word width. Only 32 is legal; an elaboration assertion enforces this.
- ROUNDS, 64, number of schedule words emitted per block. Range 16..64.
- IDX_W, $clog2(ROUNDS), width of the round index.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- blk_valid, input, 1, block offered.
- blk_ready, output, 1, block accepted when blk_valid && blk_ready.
- blk_data, input, [0:511], message block. Bit 0 is the MSB of W0. W[i] = blk_data[32i +: 32], with the lowest index as MSB.
- w_valid, output, 1, w_data is valid.
- w_ready, input, 1, consumer accepts the word.
- w_data, output, [0:31], current schedule word W[t].
- w_idx, output, IDX_W, t of the current word.
- w_last, output, 1, high when w_idx == ROUNDS-1.
- busy, output, 1, a block is in progress.

Behaviour:
- Reset (async assert, sync deassert) clears all outputs and registers to 0: w_valid=0, blk_ready=0 during reset, busy=0, window=0, t=0. State returns to IDLE.
- States:
  - IDLE: blk_ready=1, w_valid=0. On a blk_valid handshake, load window[0..15]=W0..W15, set t=0, go to RUN. There is no output in the accept cycle.
  - RUN:
    - w_valid=1. w_data=window[0], w_idx=t.
    - On w_valid && w_ready: shift the window down by one and set window[15] = σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32 (drop carries). Increment t.
    - When no handshake occurs, all outputs hold stable (AXI-style). w_data must not change while w_valid=1 && !w_ready.
  - Last word (t==ROUNDS-1 handshake):
    - If blk_valid && blk_ready in the same cycle, load the new block, set t=0, and stay in RUN. This gives zero bubble between blocks.
    - Otherwise go to IDLE.
- blk_ready = IDLE || (RUN && t==ROUNDS-1 && w_ready).
  - This combinational w_ready→blk_ready path is permitted.
  - There is no blk_valid→w_* combinational path.
- Latency: W0 is valid in the cycle after block acceptance. With w_ready tied high, a block completes in exactly ROUNDS output cycles. Sustained throughput is 1 word/cycle.
- Words W0..W15 are emitted verbatim. Expansion words are valid from t=16.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- If ROUNDS==16, the expansion result is computed but never emitted.
- blk_data is sampled only at handshake. Later changes are ignored.
- busy = (state==RUN).
- rst_n asserted mid-block aborts immediately. There is no partial output after release, and the next block starts at t=0.
- t never exceeds ROUNDS-1 (no wrap); an assertion checks this.

Decomposition:
- Shared package sha256_pkg holds:
  - word_t (logic [0:31]);
  - functions lower_sigma_zero and lower_sigma_one (extending the existing sigma_functions set);
  - constant SHA_WORDS_PER_BLOCK=16.
- One sub-module, msg_sched_expand: combinational, taking the window taps (w_tm2, w_tm7, w_tm15, w_tm16) and producing the next W. It is reused by future unrolled variants.
- The FSM, the window and the handshake stay in msg_sched_seq.

Test Plan:
1. "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 → W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB with w_last=1. Exactly 64 words are emitted, then IDLE.
2. Same block, w_ready toggled randomly with about 40% stalls → an identical word sequence. w_data/w_idx are stable during every stall, and no word is dropped or duplicated.
3. Two blocks back-to-back, blk_valid held high → the second block's W0 follows the first block's W63 on the next cycle. w_idx goes 63→0 and blk_ready pulses in the t=63 handshake cycle.
4. rst_n pulsed low at t=20 → w_valid falls asynchronously and all outputs read 0. After release, a new "abc" block yields W0=0x61626380 with w_idx=0.
5. ROUNDS=16 build, any block → W0..W15 are emitted unchanged, w_last is high at w_idx=15, and blk_ready=1 afterwards.
6. blk_data changed after acceptance during RUN → the output is unaffected. blk_valid asserted mid-RUN (t<63) → no accept, and blk_ready stays 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 word type, block geometry, scheduler state encoding
// and the lower-case sigma helpers used by message expansion.
package sha256_pkg;

   localparam int SHA_WORDS_PER_BLOCK = 16;

   // Bit 0 is the MSB, matching the big-endian message layout.
   typedef logic [0:31] word_t;

   typedef enum logic [0:0] {
      SCHED_IDLE = 1'b0,
      SCHED_RUN  = 1'b1
   } sched_state_e;

   // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
   function automatic word_t lower_sigma_zero(input word_t i_x);
      logic [31:0] w_v;
      logic [31:0] w_r;
      w_v = i_x;
      w_r = {w_v[6:0], w_v[31:7]} ^ {w_v[17:0], w_v[31:18]} ^ (w_v >> 5'd3);
      return w_r;
   endfunction

   // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
   function automatic word_t lower_sigma_one(input word_t i_x);
      logic [31:0] w_v;
      logic [31:0] w_r;
      w_v = i_x;
      w_r = {w_v[16:0], w_v[31:17]} ^ {w_v[18:0], w_v[31:19]} ^ (w_v >> 5'd10);
      return w_r;
   endfunction

endpackage

// File: rtl/msg_sched_expand.sv
// msg_sched_expand: one SHA-256 schedule expansion step.
// W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
module msg_sched_expand
   import sha256_pkg::*;
(
   input  word_t i_w_tm2,
   input  word_t i_w_tm7,
   input  word_t i_w_tm15,
   input  word_t i_w_tm16,
   output word_t o_w_next
);

   assign o_w_next = lower_sigma_one(i_w_tm2) + i_w_tm7
                   + lower_sigma_zero(i_w_tm15) + i_w_tm16;

endmodule

// File: rtl/msg_sched_seq_chk.sv
// msg_sched_seq_chk: parameter legality and protocol invariants of the
// sequential message scheduler.
module msg_sched_seq_chk #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64,
   parameter int IDX_W  = 6
) (
   input logic             clk,
   input logic             rst_n,
   input logic             i_w_valid,
   input logic             i_w_ready,
   input logic [0:31]      i_w_data,
   input logic [IDX_W-1:0] i_w_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   generate
      if (WORD_W != 32) begin : g_bad_word_w
         $error("msg_sched_seq: WORD_W must be 32");
      end
      if ((ROUNDS < 16) || (ROUNDS > 64)) begin : g_bad_rounds
         $error("msg_sched_seq: ROUNDS must lie in 16..64");
      end
   endgenerate

   // The round index returns to 0 after the last word instead of running past it.
   a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
      (i_w_valid && i_w_ready && (i_w_idx == LAST_IDX)) |=> (i_w_idx == '0));

   // A stalled word stays offered and unchanged.
   a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (i_w_valid && !i_w_ready) |=>
      (i_w_valid && $stable(i_w_data) && $stable(i_w_idx)));

endmodule

// File: rtl/msg_sched_seq.sv
// msg_sched_seq: streams the SHA-256 message schedule W[0..ROUNDS-1] of one
// 512-bit block through a 16-word sliding window, one word per handshake,
// with zero-bubble hand-over to the next block.
module msg_sched_seq
   import sha256_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64,
   parameter int IDX_W  = $clog2(ROUNDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blk_valid,
   output logic             blk_ready,
   input  logic [0:511]     blk_data,
   output logic             w_valid,
   input  logic             w_ready,
   output logic [0:31]      w_data,
   output logic [IDX_W-1:0] w_idx,
   output logic             w_last,
   output logic             busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   sched_state_e     r_state;
   sched_state_e     w_state_nxt;
   word_t            r_window [0:SHA_WORDS_PER_BLOCK-1];
   logic [IDX_W-1:0] r_t;
   logic             r_alive;
   logic             w_load;
   logic             w_shift;
   logic             w_finish;
   logic             w_blk_rdy;
   logic             w_at_last;
   word_t            w_w_next;

   assign w_at_last = (r_t == LAST_IDX);

   msg_sched_expand u_expand (
      .i_w_tm2  (r_window[14]),
      .i_w_tm7  (r_window[9]),
      .i_w_tm15 (r_window[1]),
      .i_w_tm16 (r_window[0]),
      .o_w_next (w_w_next)
   );

   // Holds blk_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alive <= 1'b0;
      end else begin
         r_alive <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SCHED_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, block acceptance and window update decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_finish    = 1'b0;
      w_blk_rdy   = 1'b0;
      case (r_state)
         SCHED_IDLE: begin
            if (r_alive) begin
               w_blk_rdy = 1'b1;
               if (blk_valid) begin
                  w_load      = 1'b1;
                  w_state_nxt = SCHED_RUN;
               end else begin
                  w_state_nxt = SCHED_IDLE;
               end
            end else begin
               w_state_nxt = SCHED_IDLE;
            end
         end
         SCHED_RUN: begin
            if (w_ready) begin
               if (w_at_last) begin
                  // Last word leaves: the next block may be taken in the same cycle.
                  w_blk_rdy = 1'b1;
                  if (blk_valid) begin
                     w_load      = 1'b1;
                     w_state_nxt = SCHED_RUN;
                  end else begin
                     w_finish    = 1'b1;
                     w_state_nxt = SCHED_IDLE;
                  end
               end else begin
                  w_shift     = 1'b1;
                  w_state_nxt = SCHED_RUN;
               end
            end else begin
               w_state_nxt = SCHED_RUN;
            end
         end
         default: begin
            w_state_nxt = SCHED_IDLE;
         end
      endcase
   end

   // Sliding window and round index: load a block, or shift in the next word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SHA_WORDS_PER_BLOCK; i++) begin
            r_window[i] <= '0;
         end
         r_t <= '0;
      end else if (w_load) begin
         for (int i = 0; i < SHA_WORDS_PER_BLOCK; i++) begin
            r_window[i] <= blk_data[32*i +: 32];
         end
         r_t <= '0;
      end else if (w_finish) begin
         r_t <= '0;
      end else if (w_shift) begin
         for (int i = 0; i < SHA_WORDS_PER_BLOCK - 1; i++) begin
            r_window[i] <= r_window[i+1];
         end
         r_window[SHA_WORDS_PER_BLOCK-1] <= w_w_next;
         r_t <= r_t + IDX_W'(1);
      end
   end

   assign blk_ready = w_blk_rdy;
   assign w_valid   = (r_state == SCHED_RUN);
   assign busy      = (r_state == SCHED_RUN);
   assign w_data    = r_window[0];
   assign w_idx     = r_t;
   assign w_last    = (r_state == SCHED_RUN) && w_at_last;

   msg_sched_seq_chk #(
      .WORD_W (WORD_W),
      .ROUNDS (ROUNDS),
      .IDX_W  (IDX_W)
   ) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_w_valid (w_valid),
      .i_w_ready (w_ready),
      .i_w_data  (w_data),
      .i_w_idx   (w_idx)
   );

endmodule

// File: tb/tb_msg_sched_seq.sv
// tb_msg_sched_seq: directed bench for the sequential SHA-256 message
// scheduler, with a 64-round and a 16-round instance.
module tb_msg_sched_seq;

   logic         clk;
   logic         rst_n;
   logic         blk_valid, blk_ready, w_valid, w_ready, w_last, busy;
   logic [0:511] blk_data;
   logic [0:31]  w_data;
   logic [5:0]   w_idx;
   logic         blk_valid16, blk_ready16, w_valid16, w_ready16, w_last16, busy16;
   logic [0:511] blk_data16;
   logic [0:31]  w_data16;
   logic [3:0]   w_idx16;

   int n_vec;
   int n_err;

   logic [0:511] abc_blk;
   logic [0:511] blk2;
   logic [31:0]  ex_a [0:63];
   logic [31:0]  ex_b [0:63];

   msg_sched_seq #(.WORD_W(32), .ROUNDS(64)) u_dut (
      .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .w_valid(w_valid), .w_ready(w_ready),
      .w_data(w_data), .w_idx(w_idx), .w_last(w_last), .busy(busy)
   );

   msg_sched_seq #(.WORD_W(32), .ROUNDS(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid16), .blk_ready(blk_ready16),
      .blk_data(blk_data16), .w_valid(w_valid16), .w_ready(w_ready16),
      .w_data(w_data16), .w_idx(w_idx16), .w_last(w_last16), .busy(busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] bs0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] bs1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   task automatic gen_sched(input logic [0:511] blk, input int which);
      logic [31:0] w [0:63];
      for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
      for (int i = 16; i < 64; i++) w[i] = bs1(w[i-2]) + w[i-7] + bs0(w[i-15]) + w[i-16];
      for (int i = 0; i < 64; i++) begin
         if (which == 0) ex_a[i] = w[i];
         else            ex_b[i] = w[i];
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL rst_w_valid: got %b want 0", w_valid); end
      n_vec++; if (blk_ready !== 1'b0) begin n_err++; $display("FAIL rst_blk_ready: got %b want 0", blk_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_vec++; if (w_data !== 32'h0) begin n_err++; $display("FAIL rst_w_data: got %h want 0", w_data); end
      n_vec++; if (w_idx !== 6'd0) begin n_err++; $display("FAIL rst_w_idx: got %0d want 0", w_idx); end
      n_vec++; if (w_last !== 1'b0) begin n_err++; $display("FAIL rst_w_last: got %b want 0", w_last); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      n_vec++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL idle_blk_ready: got %b want 1", blk_ready); end
      n_vec++; if (blk_ready16 !== 1'b1) begin n_err++; $display("FAIL idle_blk_ready16: got %b want 1", blk_ready16); end
      n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL idle_w_valid: got %b want 0", w_valid); end
   endtask

   task automatic test_abc;
      @(posedge clk); #1;
      blk_valid = 1'b1; blk_data = abc_blk; w_ready = 1'b1;
      #1;
      n_vec++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL abc_accept: got %b want 1", blk_ready); end
      @(posedge clk); #1;
      blk_valid = 1'b0; blk_data = '0;
      for (int k = 0; k < 64; k++) begin
         #1;
         n_vec++; if (w_valid !== 1'b1) begin n_err++; $display("FAIL abc_valid[%0d]: got %b want 1", k, w_valid); end
         n_vec++; if (w_data !== ex_a[k]) begin n_err++; $display("FAIL abc_data[%0d]: got %h want %h", k, w_data, ex_a[k]); end
         n_vec++; if (w_idx !== 6'(k)) begin n_err++; $display("FAIL abc_idx[%0d]: got %0d want %0d", k, w_idx, k); end
         n_vec++; if (w_last !== (k == 63)) begin n_err++; $display("FAIL abc_last[%0d]: got %b want %b", k, w_last, (k == 63)); end
         n_vec++; if (blk_ready !== (k == 63)) begin n_err++; $display("FAIL abc_blk_ready[%0d]: got %b want %b", k, blk_ready, (k == 63)); end
         if (k == 16) begin n_vec++; if (w_data !== 32'h61626380) begin n_err++; $display("FAIL abc_w16: got %h want 61626380", w_data); end end
         if (k == 17) begin n_vec++; if (w_data !== 32'h000F0000) begin n_err++; $display("FAIL abc_w17: got %h want 000f0000", w_data); end end
         if (k == 18) begin n_vec++; if (w_data !== 32'h7DA86405) begin n_err++; $display("FAIL abc_w18: got %h want 7da86405", w_data); end end
         if (k == 63) begin n_vec++; if (w_data !== 32'h12B1EDEB) begin n_err++; $display("FAIL abc_w63: got %h want 12b1edeb", w_data); end end
         @(posedge clk); #1;
      end
      #1;
      n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL abc_end_valid: got %b want 0", w_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abc_end_busy: got %b want 0", busy); end
      n_vec++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL abc_end_blk_ready: got %b want 1", blk_ready); end
   endtask

   // Random stalls, blk_data scribbled after acceptance, blk_valid raised mid-block.
   task automatic test_stall;
      int          cnt;
      int          cyc;
      logic        prev_stall;
      logic [0:31] prev_data;
      logic [5:0]  prev_idx;
      @(posedge clk); #1;
      blk_valid = 1'b1; blk_data = abc_blk; w_ready = 1'b0;
      @(posedge clk); #1;
      cnt = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
      while (cnt < 64 && cyc < 1000) begin
         blk_valid = (cnt < 63);
         blk_data  = {$urandom, $urandom, $urandom, $urandom, 384'h0};
         w_ready   = ($urandom_range(99, 0) >= 40);
         #1;
         n_vec++; if (w_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", cnt, w_valid); end
         if (prev_stall) begin
            n_vec++; if (w_data !== prev_data) begin n_err++; $display("FAIL stall_hold_data[%0d]: got %h want %h", cnt, w_data, prev_data); end
            n_vec++; if (w_idx !== prev_idx) begin n_err++; $display("FAIL stall_hold_idx[%0d]: got %0d want %0d", cnt, w_idx, prev_idx); end
         end
         n_vec++; if (blk_ready !== (w_ready && cnt == 63)) begin n_err++; $display("FAIL stall_blk_ready[%0d]: got %b want %b", cnt, blk_ready, (w_ready && cnt == 63)); end
         if (w_ready) begin
            n_vec++; if (w_data !== ex_a[cnt]) begin n_err++; $display("FAIL stall_data[%0d]: got %h want %h", cnt, w_data, ex_a[cnt]); end
            n_vec++; if (w_idx !== 6'(cnt)) begin n_err++; $display("FAIL stall_idx[%0d]: got %0d want %0d", cnt, w_idx, cnt); end
            n_vec++; if (w_last !== (cnt == 63)) begin n_err++; $display("FAIL stall_last[%0d]: got %b want %b", cnt, w_last, (cnt == 63)); end
            cnt++;
         end
         prev_stall = !w_ready; prev_data = w_data; prev_idx = w_idx;
         cyc++;
         @(posedge clk); #1;
      end
      blk_valid = 1'b0; w_ready = 1'b1;
      n_vec++; if (cnt != 64) begin n_err++; $display("FAIL stall_timeout: got %0d words want 64", cnt); end
      #1;
      n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL stall_end_valid: got %b want 0", w_valid); end
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      blk_valid = 1'b1; blk_data = abc_blk; w_ready = 1'b1;
      @(posedge clk); #1;
      blk_data = blk2;
      for (int k = 0; k < 128; k++) begin
         blk_valid = (k <= 63);
         #1;
         n_vec++; if (w_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, w_valid); end
         n_vec++; if (w_data !== ((k < 64) ? ex_a[k] : ex_b[k-64])) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, w_data, ((k < 64) ? ex_a[k] : ex_b[k-64])); end
         n_vec++; if (w_idx !== 6'(k % 64)) begin n_err++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", k, w_idx, k % 64); end
         n_vec++; if (w_last !== (k % 64 == 63)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", k, w_last, (k % 64 == 63)); end
         n_vec++; if (blk_ready !== (k % 64 == 63)) begin n_err++; $display("FAIL b2b_blk_ready[%0d]: got %b want %b", k, blk_ready, (k % 64 == 63)); end
         @(posedge clk); #1;
      end
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      int cyc;
      @(posedge clk); #1;
      blk_valid = 1'b1; blk_data = abc_blk; w_ready = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      n_vec++; if (w_idx !== 6'd20) begin n_err++; $display("FAIL rmid_pre_idx: got %0d want 20", w_idx); end
      n_vec++; if (w_data !== ex_a[20]) begin n_err++; $display("FAIL rmid_pre_data: got %h want %h", w_data, ex_a[20]); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", w_valid); end
      n_vec++; if (w_data !== 32'h0) begin n_err++; $display("FAIL rmid_data: got %h want 0", w_data); end
      n_vec++; if (w_idx !== 6'd0) begin n_err++; $display("FAIL rmid_idx: got %0d want 0", w_idx); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
      n_vec++; if (blk_ready !== 1'b0) begin n_err++; $display("FAIL rmid_blk_ready: got %b want 0", blk_ready); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #2;
      n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL rmid_after_valid: got %b want 0", w_valid); end
      n_vec++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL rmid_after_ready: got %b want 1", blk_ready); end
      blk_valid = 1'b1; blk_data = abc_blk;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      #1;
      n_vec++; if (w_data !== 32'h61626380) begin n_err++; $display("FAIL rmid_w0: got %h want 61626380", w_data); end
      n_vec++; if (w_idx !== 6'd0) begin n_err++; $display("FAIL rmid_w0_idx: got %0d want 0", w_idx); end
      cyc = 0;
      while (w_valid === 1'b1 && cyc < 200) begin
         @(posedge clk); #2;
         cyc++;
      end
      n_vec++; if (cyc != 64) begin n_err++; $display("FAIL rmid_drain: got %0d cycles want 64", cyc); end
   endtask

   task automatic test_rounds16;
      @(posedge clk); #1;
      blk_valid16 = 1'b1; blk_data16 = blk2; w_ready16 = 1'b1;
      #1;
      n_vec++; if (blk_ready16 !== 1'b1) begin n_err++; $display("FAIL r16_accept: got %b want 1", blk_ready16); end
      @(posedge clk); #1;
      blk_valid16 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         n_vec++; if (w_valid16 !== 1'b1) begin n_err++; $display("FAIL r16_valid[%0d]: got %b want 1", k, w_valid16); end
         n_vec++; if (w_data16 !== ex_b[k]) begin n_err++; $display("FAIL r16_data[%0d]: got %h want %h", k, w_data16, ex_b[k]); end
         n_vec++; if (w_idx16 !== 4'(k)) begin n_err++; $display("FAIL r16_idx[%0d]: got %0d want %0d", k, w_idx16, k); end
         n_vec++; if (w_last16 !== (k == 15)) begin n_err++; $display("FAIL r16_last[%0d]: got %b want %b", k, w_last16, (k == 15)); end
         @(posedge clk); #1;
      end
      #1;
      n_vec++; if (w_valid16 !== 1'b0) begin n_err++; $display("FAIL r16_end_valid: got %b want 0", w_valid16); end
      n_vec++; if (blk_ready16 !== 1'b1) begin n_err++; $display("FAIL r16_end_ready: got %b want 1", blk_ready16); end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b1;
      blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
      blk_valid16 = 1'b0; blk_data16 = '0; w_ready16 = 1'b0;
      abc_blk = {32'h61626380, 448'h0, 32'h00000018};
      for (int i = 0; i < 16; i++) blk2[32*i +: 32] = 32'h9E3779B9 * 32'(i + 1);
      gen_sched(abc_blk, 0);
      gen_sched(blk2, 1);
      test_reset;
      test_abc;
      test_stall;
      test_back_to_back;
      test_reset_mid;
      test_rounds16;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
